// File: rtl/bregs_pkg.sv
// rtl/bregs_pkg.sv - shared encodings for the register-bank arbiter
package bregs_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam logic C0 = 1'b0;
  localparam logic C1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with registered priority
module rr_arb2
  import bregs_pkg::*;
(
  input  logic       clk,
  input  logic       clk_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] win,
  output logic       win_id,
  output logic       prio
);

  always_comb begin
    win_id = prio;
    if (req == 2'b01)
      win_id = C0;
    else if (req == 2'b10)
      win_id = C1;
    win = 2'b00;
    if (req != 2'b00)
      win = (win_id == C1) ? 2'b10 : 2'b01;
  end

  // Priority passes to the loser of every grant.
  always_ff @(posedge clk) begin
    if (!clk_n)
      prio <= C0;
    else if (update)
      prio <= ~win_id;
  end

endmodule

// File: rtl/bregs_arbiter.sv
// rtl/bregs_arbiter.sv - two-client arbiter/sequencer for the 4-entry register bank
module bregs_arbiter
  import bregs_pkg::*;
#(
  parameter int Size = 8,
  parameter int AW   = 2
) (
  input  logic            clk,
  input  logic            clk_n,
  input  logic            req_0,
  input  logic            wr_0,
  input  logic [AW-1:0]   addr1_0,
  input  logic [AW-1:0]   addr2_0,
  input  logic [Size-1:0] wdata_0,
  output logic            gnt_0,
  output logic            rvalid_0,
  output logic [Size-1:0] rdata1_0,
  output logic [Size-1:0] rdata2_0,
  input  logic            req_1,
  input  logic            wr_1,
  input  logic [AW-1:0]   addr1_1,
  input  logic [AW-1:0]   addr2_1,
  input  logic [Size-1:0] wdata_1,
  output logic            gnt_1,
  output logic            rvalid_1,
  output logic [Size-1:0] rdata1_1,
  output logic [Size-1:0] rdata2_1,
  output logic [AW-1:0]   ba1,
  output logic [AW-1:0]   ba2,
  output logic [Size-1:0] bwd,
  output logic            bwe,
  input  logic [Size-1:0] brd1,
  input  logic [Size-1:0] brd2
);

  state_e     state;
  op_e        op;
  logic       owner;
  logic [1:0] win;
  logic       win_id;
  logic       prio;
  logic       arb_update;

  assign arb_update = (state == S_IDLE) && (req_0 || req_1);

  rr_arb2 u_arb (
    .clk    (clk),
    .clk_n  (clk_n),
    .req    ({req_1, req_0}),
    .update (arb_update),
    .win    (win),
    .win_id (win_id),
    .prio   (prio)
  );

  // The bank-driving registers double as the request latch for addr1/addr2/wdata.
  always_ff @(posedge clk) begin
    if (!clk_n) begin
      state    <= S_IDLE;
      op       <= OP_READ;
      owner    <= C0;
      gnt_0    <= 1'b0;
      gnt_1    <= 1'b0;
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
      rdata1_0 <= '0;
      rdata2_0 <= '0;
      rdata1_1 <= '0;
      rdata2_1 <= '0;
      ba1      <= '0;
      ba2      <= '0;
      bwd      <= '0;
      bwe      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_update) begin
            owner <= win_id;
            gnt_0 <= win[0];
            gnt_1 <= win[1];
            if (win_id == C1) begin
              op  <= op_e'(wr_1);
              ba1 <= addr1_1;
              ba2 <= addr2_1;
              bwd <= wdata_1;
              bwe <= wr_1;
            end else begin
              op  <= op_e'(wr_0);
              ba1 <= addr1_0;
              ba2 <= addr2_0;
              bwd <= wdata_0;
              bwe <= wr_0;
            end
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          gnt_0 <= 1'b0;
          gnt_1 <= 1'b0;
          bwe   <= 1'b0;
          if (owner == C1) begin
            rvalid_1 <= 1'b1;
            if (op == OP_READ) begin
              rdata1_1 <= brd1;
              rdata2_1 <= brd2;
            end
          end else begin
            rvalid_0 <= 1'b1;
            if (op == OP_READ) begin
              rdata1_0 <= brd1;
              rdata2_0 <= brd2;
            end
          end
          state <= S_RESP;
        end
        S_RESP: begin
          rvalid_0 <= 1'b0;
          rvalid_1 <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
